// File: rtl/agdc_pkg.sv
// agdc_pkg: state encoding shared by the garage door controller files
package agdc_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    MV_UP = 2'b01,
    MV_DN = 2'b10,
    BAD   = 2'b11
  } state_t;
endpackage

// File: rtl/agdc_sync.sv
// agdc_sync: STAGES-deep 1-bit async-reset synchronizer, wire-through when STAGES is 0
module agdc_sync #(
  parameter int STAGES = 0
) (
  input  logic CLK,
  input  logic RST,
  input  logic d,
  output logic q
);
  if (STAGES == 0) begin : g_wire
    logic unused_clk_rst;
    assign unused_clk_rst = CLK ^ RST;
    assign q = d;
  end else begin : g_ff
    logic [STAGES-1:0] ff;
    // shift the input through the flop chain, cleared by reset
    always_ff @(posedge CLK or negedge RST)
      if (!RST) ff <= '0;
      else begin
        ff[0] <= d;
        for (int i = 1; i < STAGES; i++) ff[i] <= ff[i-1];
      end
    assign q = ff[STAGES-1];
  end
endmodule

// File: rtl/agdc.sv
// agdc: garage door Moore FSM driving the motor up or down between two limit switches
module agdc
  import agdc_pkg::*;
#(
  parameter int SYNC_STAGES = 0
) (
  input  logic CLK,
  input  logic RST,
  input  logic activate,
  input  logic UP_Max,
  input  logic DN_Max,
  output logic UP_M,
  output logic DN_M
);
  logic act_s, up_s, dn_s;
  state_t state, state_nx;
  agdc_sync #(.STAGES(SYNC_STAGES)) u_sync_act (.CLK(CLK), .RST(RST), .d(activate), .q(act_s));
  agdc_sync #(.STAGES(SYNC_STAGES)) u_sync_up  (.CLK(CLK), .RST(RST), .d(UP_Max),   .q(up_s));
  agdc_sync #(.STAGES(SYNC_STAGES)) u_sync_dn  (.CLK(CLK), .RST(RST), .d(DN_Max),   .q(dn_s));
  // state register, reset drops the motor at once
  always_ff @(posedge CLK or negedge RST)
    if (!RST) state <= IDLE;
    else state <= state_nx;
  // next state: start only from a single clean limit, stop on reaching the target limit
  always_comb begin
    state_nx = IDLE;
    case (state)
      IDLE:    state_nx = (act_s && dn_s && !up_s) ? MV_UP :
                          (act_s && up_s && !dn_s) ? MV_DN : IDLE;
      MV_UP:   state_nx = up_s ? IDLE : MV_UP;
      MV_DN:   state_nx = dn_s ? IDLE : MV_DN;
      default: state_nx = IDLE;
    endcase
  end
  // motor commands decoded from the state; the illegal code drives neither
  always_comb begin
    UP_M = (state == MV_UP);
    DN_M = (state == MV_DN);
  end
endmodule

// File: tb/tb_agdc.sv
// tb_agdc: randomized scoreboard bench for agdc with unsynchronized and 2-stage-synchronized instances
module tb_agdc;
  logic CLK = 0;
  logic RST = 0;
  logic activate = 0;
  logic UP_Max = 0;
  logic DN_Max = 0;
  logic up0, dn0, up2, dn2;
  int total = 0;
  int bad = 0;
  int mode0, mode2, k;
  logic [2:0] hist2[$];
  typedef struct {
    logic up0, dn0, up2, dn2;
  } exp_t;
  exp_t sb[$];

  agdc #(.SYNC_STAGES(0)) dut0 (.CLK(CLK), .RST(RST), .activate(activate), .UP_Max(UP_Max),
                                .DN_Max(DN_Max), .UP_M(up0), .DN_M(dn0));
  agdc #(.SYNC_STAGES(2)) dut2 (.CLK(CLK), .RST(RST), .activate(activate), .UP_Max(UP_Max),
                                .DN_Max(DN_Max), .UP_M(up2), .DN_M(dn2));

  always #10 CLK = ~CLK;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // door behaviour: 0 = resting, 1 = opening, 2 = closing
  function automatic int next_mode(input int m, input logic a, input logic u, input logic d);
    if (m == 1) return u ? 0 : 1;
    if (m == 2) return d ? 0 : 2;
    if (a && d && !u) return 1;
    if (a && u && !d) return 2;
    return 0;
  endfunction

  task automatic model_reset();
    mode0 = 0;
    mode2 = 0;
    hist2.delete();
    repeat (2) hist2.push_back(3'b000);
  endtask

  task automatic step(input logic a, input logic u, input logic d);
    logic [2:0] e;
    exp_t x;
    @(negedge CLK);
    activate = a;
    UP_Max = u;
    DN_Max = d;
    mode0 = next_mode(mode0, a, u, d);
    hist2.push_back({a, u, d});
    e = hist2.pop_front();
    mode2 = next_mode(mode2, e[2], e[1], e[0]);
    x.up0 = (mode0 == 1);
    x.dn0 = (mode0 == 2);
    x.up2 = (mode2 == 1);
    x.dn2 = (mode2 == 2);
    sb.push_back(x);
    @(posedge CLK);
    #1;
  endtask

  task automatic rst_hold();
    #1;
    chk("rst_async_up0", up0, 0);
    chk("rst_async_dn0", dn0, 0);
    chk("rst_async_up2", up2, 0);
    chk("rst_async_dn2", dn2, 0);
    model_reset();
    @(posedge CLK);
    @(posedge CLK);
    #5;
    RST = 1;
    activate = 0;
    UP_Max = 0;
    DN_Max = 0;
  endtask

  task automatic do_reset(input logic a, input logic u, input logic d);
    @(negedge CLK);
    RST = 0;
    activate = a;
    UP_Max = u;
    DN_Max = d;
    rst_hold();
  endtask

  // monitor: compare both instances to the scoreboard after every edge
  initial begin
    exp_t x;
    forever begin
      @(posedge CLK);
      #2;
      chk("mutex", {up0 & dn0, up2 & dn2}, 0);
      if (sb.size() > 0) begin
        x = sb.pop_front();
        chk("sb_out0", {up0, dn0}, {x.up0, x.dn0});
        chk("sb_out2", {up2, dn2}, {x.up2, x.dn2});
      end
    end
  end

  initial begin
    model_reset();
    activate = 1;
    UP_Max = 1;
    DN_Max = 1;
    rst_hold();
    repeat (3) begin
      step(0, 0, 0);
      chk("post_rst_idle", {up0, dn0}, 0);
    end
    repeat (5) begin
      step(1, 0, 0);
      chk("noop", {up0, dn0}, 0);
    end
    k = 0;
    for (int i = 1; i <= 6; i++) begin
      step(1, 1, 0);
      if (i == 1) chk("close_start", {up0, dn0}, 2'b01);
      if (dn2 && k == 0) k = i;
    end
    chk("sync_latency", k, 3);
    repeat (4) begin
      step(0, 0, 0);
      chk("closing_hold", {up0, dn0}, 2'b01);
    end
    repeat (2) step(1, 0, 0);
    step(1, 0, 1);
    chk("closed_idle", {up0, dn0}, 0);
    step(1, 0, 1);
    chk("reopen", {up0, dn0}, 2'b10);
    repeat (10) begin
      step(0, 0, 0);
      chk("opening_hold", {up0, dn0}, 2'b10);
    end
    step(0, 1, 0);
    chk("opened_idle", {up0, dn0}, 0);
    repeat (3) step(0, 1, 0);
    repeat (5) begin
      step(1, 1, 1);
      chk("both_limits", {up0, dn0}, 0);
    end
    step(1, 0, 1);
    step(0, 0, 0);
    chk("pre_rst_up", up0, 1);
    do_reset(1, 0, 1);
    repeat (3) begin
      step(0, 0, 0);
      chk("rst_no_resume", {up0, dn0}, 0);
    end
    repeat (400) begin
      if ($urandom_range(0, 79) == 0)
        do_reset(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      else
        step(1'($urandom_range(0, 1)), $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0);
    end
    @(negedge CLK);
    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
